// File: rtl/pin_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pin_entry_pkg
// Purpose  : Shared constants and types for the keypad PIN/amount entry path.
//            Entry state enum, number of digit slots, largest legal digit
//            and the slot index width.
// Revision : 1.0 - initial release
// ============================================================================
package pin_entry_pkg;

  localparam int         NUM_SLOTS  = 4;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;
  localparam int         SLOT_IDX_W = $clog2(NUM_SLOTS);
  localparam int         COUNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pin_digit_check.sv
`default_nettype none
// ============================================================================
// Module   : pin_digit_check
// Purpose  : Combinational legality check for a keypad digit code. Shared
//            with the keypad decoder.
// Ports    : digit [3:0] in  - digit code under test
//            legal       out - 1 when digit <= MAX_DIGIT
// Revision : 1.0 - initial release
// ============================================================================
module pin_digit_check #(
  parameter logic [3:0] MAX_DIGIT = pin_entry_pkg::MAX_DIGIT
) (
  input  logic [3:0] digit,
  output logic       legal
);

  assign legal = (digit <= MAX_DIGIT);

endmodule
`default_nettype wire

// File: rtl/pin_digit_demux.sv
`default_nettype none
// ============================================================================
// Module   : pin_digit_demux
// Purpose  : Collects keypad digits one at a time into four nibble slots,
//            tracks entry progress (IDLE / ENTRY / LOCKED), rejects illegal
//            strobes with a one-cycle err pulse and locks the value on enter.
//            Strobe priority: clear > back > enter > digit_valid.
// Config   : PIN_BACKSPACE_EN - when defined, back deletes the last digit.
//            When undefined, back is ignored entirely.
// Ports    : clk, rst_n (async active-low)
//            digit[3:0], digit_valid, enter, clear, back  - keypad strobes
//            slot0..slot3[3:0] - digit registers, slot0 = first digit
//            count[2:0], full, locked - entry status
//            done, err - registered one-cycle pulses
// Revision : 1.0 - initial release
// ============================================================================
module pin_digit_demux
  import pin_entry_pkg::*;
#(
  parameter int         NUM_SLOTS = pin_entry_pkg::NUM_SLOTS,
  parameter logic [3:0] MAX_DIGIT = pin_entry_pkg::MAX_DIGIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       enter,
  input  logic       clear,
  input  logic       back,
  output logic [3:0] slot0,
  output logic [3:0] slot1,
  output logic [3:0] slot2,
  output logic [3:0] slot3,
  output logic [2:0] count,
  output logic       full,
  output logic       locked,
  output logic       done,
  output logic       err
);

  localparam logic [COUNT_W-1:0] C_FULL_COUNT = COUNT_W'(NUM_SLOTS);

  state_t                        r_state, w_state_nxt;
  logic [NUM_SLOTS-1:0][3:0]     r_slots, w_slots_nxt;
  logic [COUNT_W-1:0]            r_count, w_count_nxt;
  logic                          r_done, w_done_nxt;
  logic                          r_err, w_err_nxt;
  logic                          w_legal;
  logic                          w_full;
  logic [SLOT_IDX_W-1:0]         w_wr_idx;

  pin_digit_check #(
    .MAX_DIGIT (MAX_DIGIT)
  ) u_check (
    .digit (digit),
    .legal (w_legal)
  );

  assign w_full   = (r_count == C_FULL_COUNT);
  assign w_wr_idx = r_count[SLOT_IDX_W-1:0];

`ifdef PIN_BACKSPACE_EN
  // Slot of the most recent digit; only meaningful while count >= 1.
  logic [SLOT_IDX_W-1:0] w_back_idx;
  assign w_back_idx = SLOT_IDX_W'(r_count - 3'd1);
`else
  logic w_unused_back;
  assign w_unused_back = back;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_slots <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_slots <= w_slots_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Only the highest-priority strobe present is acted upon; lower ones in the
  // same cycle fall through the else-chain without raising err.
  always_comb begin
    w_state_nxt = r_state;
    w_slots_nxt = r_slots;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_slots_nxt = '0;
      w_count_nxt = '0;
    end
`ifdef PIN_BACKSPACE_EN
    else if (back) begin
      if (r_state == ST_ENTRY) begin
        w_slots_nxt[w_back_idx] = 4'd0;
        w_count_nxt             = r_count - 3'd1;
        if (r_count == 3'd1) begin
          w_state_nxt = ST_IDLE;
        end
      end else if (r_state == ST_IDLE) begin
        w_err_nxt = 1'b1;
      end
    end
`endif
    else if (enter) begin
      if (r_state == ST_ENTRY && w_full) begin
        w_state_nxt = ST_LOCKED;
        w_done_nxt  = 1'b1;
      end else if (r_state != ST_LOCKED) begin
        w_err_nxt = 1'b1;
      end
    end else if (digit_valid) begin
      if (!w_legal || w_full || r_state == ST_LOCKED) begin
        w_err_nxt = 1'b1;
      end else begin
        w_slots_nxt[w_wr_idx] = digit;
        w_count_nxt           = r_count + 3'd1;
        w_state_nxt           = ST_ENTRY;
      end
    end
  end

  assign slot0  = r_slots[0];
  assign slot1  = r_slots[1];
  assign slot2  = r_slots[2];
  assign slot3  = r_slots[3];
  assign count  = r_count;
  assign full   = w_full;
  assign locked = (r_state == ST_LOCKED);
  assign done   = r_done;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pin_digit_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_pin_digit_demux
// Purpose  : Self-checking bench for pin_digit_demux. Directed scenarios then
//            random strobes, compared against a queue-based reference model.
//            Honours PIN_BACKSPACE_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pin_digit_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_valid = 1'b0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       back = 1'b0;
  logic [3:0] slot0, slot1, slot2, slot3;
  logic [2:0] count;
  logic       full, locked, done, err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: entered digits as a queue, plus lock flag and pulses.
  int m_q[$];
  bit m_locked;
  bit m_done;
  bit m_err;

  pin_digit_demux dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit       (digit),
    .digit_valid (digit_valid),
    .enter       (enter),
    .clear       (clear),
    .back        (back),
    .slot0       (slot0),
    .slot1       (slot1),
    .slot2       (slot2),
    .slot3       (slot3),
    .count       (count),
    .full        (full),
    .locked      (locked),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_slot(input int i);
    return (i < m_q.size()) ? m_q[i] : 0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_locked = 0;
    m_done   = 0;
    m_err    = 0;
  endtask

  task automatic model_step(input int d, input bit dv, input bit en, input bit cl, input bit bk);
    bit use_back;
`ifdef PIN_BACKSPACE_EN
    use_back = bk;
`else
    use_back = 0;
`endif
    m_done = 0;
    m_err  = 0;
    if (cl) begin
      m_q.delete();
      m_locked = 0;
    end else if (use_back) begin
      if (!m_locked) begin
        if (m_q.size() == 0) m_err = 1;
        else void'(m_q.pop_back());
      end
    end else if (en) begin
      if (!m_locked) begin
        if (m_q.size() == 4) begin
          m_locked = 1;
          m_done   = 1;
        end else begin
          m_err = 1;
        end
      end
    end else if (dv) begin
      if (m_locked || d > 9 || m_q.size() == 4) m_err = 1;
      else m_q.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".slot0"},  32'(slot0),  32'(m_slot(0)));
    chk({tag, ".slot1"},  32'(slot1),  32'(m_slot(1)));
    chk({tag, ".slot2"},  32'(slot2),  32'(m_slot(2)));
    chk({tag, ".slot3"},  32'(slot3),  32'(m_slot(3)));
    chk({tag, ".count"},  32'(count),  32'(m_q.size()));
    chk({tag, ".full"},   32'(full),   32'(m_q.size() == 4));
    chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
    chk({tag, ".done"},   32'(done),   32'(m_done));
    chk({tag, ".err"},    32'(err),    32'(m_err));
  endtask

  // Drive one cycle of strobes, let the edge sample them, then compare.
  task automatic cycle(input string tag, input int d, input bit dv, input bit en,
                       input bit cl, input bit bk);
    digit       = 4'(d);
    digit_valid = dv;
    enter       = en;
    clear       = cl;
    back        = bk;
    @(posedge clk);
    model_step(d, dv, en, cl, bk);
    #1;
    digit_valid = 0;
    enter       = 0;
    clear       = 0;
    back        = 0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Four digits back-to-back, then commit.
    for (int i = 1; i <= 4; i++) cycle("dig1234", i, 1, 0, 0, 0);
    cycle("enter_full", 0, 0, 1, 0, 0);
    cycle("after_done", 0, 0, 0, 0, 0);
    cycle("dig_locked", 3, 1, 0, 0, 0);
    cycle("enter_locked", 0, 0, 1, 0, 0);

    // Illegal digit from empty, then digit when full.
    cycle("clr0", 0, 0, 0, 1, 0);
    cycle("illegal_B", 11, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("fill", 2 * i + 1, 1, 0, 0, 0);
    cycle("dig_full", 5, 1, 0, 0, 0);

    // Early enter, then clear.
    cycle("clr1", 0, 0, 0, 1, 0);
    cycle("d2a", 4, 1, 0, 0, 0);
    cycle("d2b", 7, 1, 0, 0, 0);
    cycle("enter_early", 0, 0, 1, 0, 0);
    cycle("enter_idle_clr", 0, 0, 0, 1, 0);
    cycle("enter_idle", 0, 0, 1, 0, 0);

    // Digit coinciding with clear is dropped.
    cycle("dig_with_clr", 7, 1, 0, 1, 0);

    // Backspace sequence (effect depends on PIN_BACKSPACE_EN).
    cycle("bk_d9", 9, 1, 0, 0, 0);
    cycle("bk_d8", 8, 1, 0, 0, 0);
    cycle("back1", 0, 0, 0, 0, 1);
    cycle("back2", 0, 0, 0, 0, 1);
    cycle("back3", 0, 0, 0, 0, 1);
    cycle("back_with_dig", 3, 1, 0, 0, 1);

    // Asynchronous reset mid-entry.
    cycle("ar_clr", 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle("ar_fill", i + 1, 1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    rst_n = 1'b1;
    cycle("after_rst", 6, 1, 0, 0, 0);

    // Random strobes.
    for (int n = 0; n < 600; n++) begin
      int  d;
      bit  dv, en, cl, bk;
      d  = (($urandom % 4) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      dv = ($urandom % 100) < 55;
      en = ($urandom % 100) < 12;
      cl = ($urandom % 100) < 5;
      bk = ($urandom % 100) < 12;
      cycle("rand", d, dv, en, cl, bk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
